alu_md_control: RTL and testbench
=================================

ALU_MD_CONTROL -- requirements
Module: alu_md_control

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width (even, >=8).
REQ-002 Parameter CTRL_W, default 4, ALUCtrl width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ALUOp  input  2  0 = add, 1 = subtract, 2 = decode Function, 3 = reserved.
REQ-006 Function  input  6  R-type funct field.
REQ-007 start  input  1  qualifies a multiply/divide/move-to request in the current cycle.
REQ-008 A, B  input  WIDTH  rs and rt operands.
REQ-009 ALUCtrl  output  CTRL_W  ALU operation code (combinational).
REQ-010 illegal  output  1  ALUOp=2 with an unrecognised funct, or ALUOp=3 (combinational).
REQ-011 busy  output  1  multiply or divide in progress.
REQ-012 done  output  1  one-cycle pulse when HI/LO receive a result.
REQ-013 hilo_out  output  WIDTH  HI when funct=010000 (mfhi), otherwise LO (combinational).

Function
REQ-014 ALUOp=0 -> 0110; ALUOp=1 -> 1110; ALUOp=3 -> 0110 with illegal=1.
REQ-015 ALUOp=2 decode: 100000 -> 0110, 100010 -> 1110, 100100 -> 0000, 100101 -> 0001, 100110 -> 0010, 100111 -> 0011, 101010 -> 1111.
REQ-016 ALUOp=2 MDU funct codes (mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011) -> ALUCtrl 0110 with illegal=0.
REQ-017 Any other funct with ALUOp=2 -> ALUCtrl 0110 with illegal=1; no latch is inferred on any path.
REQ-018 The FSM has the states IDLE, MUL, DIV, FIX and DONE.
REQ-019 In IDLE, start=1 with ALUOp=2 and a mult/multu funct captures A and B and enters MUL; a div/divu funct captures A and B and enters DIV.
REQ-020 In IDLE, start=1 with mthi writes A to HI at the next edge, and with mtlo writes A to LO; no FSM transition occurs.
REQ-021 Signed operations take operand magnitudes at capture and record the result signs.
REQ-022 MUL performs a shift-add over exactly WIDTH cycles; DIV performs a restoring divide over exactly WIDTH cycles.
REQ-023 FIX lasts one cycle, applies sign correction (quotient negative if signs differ; remainder takes the dividend's sign) and enters DONE.
REQ-024 HI/LO are written on the FIX->DONE edge; done=1 only in DONE, which lasts one cycle and then returns to IDLE.
REQ-025 Latency: request accepted at edge k; done high during the cycle after edge k+WIDTH+1 (WIDTH+2 edges in total).
REQ-026 busy=1 in MUL, DIV and FIX; busy=0 in IDLE and DONE.
REQ-027 While busy=1, start is ignored entirely, including mthi/mtlo; HI/LO are not altered.
REQ-028 In DONE, a new start is accepted exactly as in IDLE.
REQ-029 Product: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2*WIDTH result.
REQ-030 Divide: LO = quotient, HI = remainder.
REQ-031 Divide by zero: LO = all ones, HI = dividend; latency unchanged.
REQ-032 Signed overflow (most-negative / -1): LO = most-negative, HI = 0.

Reset
REQ-033 reset=1 at an edge forces IDLE, HI = LO = 0 and the iteration counter to 0, clearing all captured operands.
REQ-034 While reset is held, and on the cycle after it is released, busy=0 and done=0.
REQ-035 reset asserted mid-operation aborts it: no done pulse and no HI/LO write occur.

Structure
REQ-036 A shared package alu_pkg holds the ALUCtrl encodings, the funct codes, the ALUOp values and the FSM state enum.
REQ-037 The iterative datapath (operand registers, counter, add/sub, sign fix) is a single sub-module, mdu_core.
REQ-038 The decode logic, HI/LO registers and FSM are in alu_md_control.

Verification
REQ-039 ALUOp=2, Function=101010 -> ALUCtrl=1111, illegal=0; Function=000000 -> ALUCtrl=0110, illegal=1.
REQ-040 mult A=0xFFFFFFFE, B=3 -> done after 34 edges, HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-041 div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 -> LO=0xFFFFFFFF, HI=0x00000007.
REQ-042 div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.
REQ-043 mthi A=0x12345678 issued while busy -> ignored, HI unchanged; issued in IDLE -> HI=0x12345678 next cycle; mfhi -> hilo_out=0x12345678.
REQ-044 reset at cycle 10 of a mult -> busy=0 next cycle, HI=LO=0, no done pulse within 40 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : alu_pkg                                                      |
// | Purpose : Shared encodings for the ALU control / multiply-divide unit: |
// |           ALUOp values, ALUCtrl codes, R-type funct codes and the      |
// |           multiply/divide sequencer state type.                        |
// | Ports   : none (package)                                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package alu_pkg;

  // ALUOp values presented by the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;
  localparam logic [1:0] ALUOP_RSVD  = 2'd3;

  // ALUCtrl encodings
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_XOR = 4'b0010;
  localparam logic [3:0] CTRL_NOR = 4'b0011;
  localparam logic [3:0] CTRL_ADD = 4'b0110;
  localparam logic [3:0] CTRL_SUB = 4'b1110;
  localparam logic [3:0] CTRL_SLT = 4'b1111;

  // R-type funct codes: ALU operations
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  // R-type funct codes: multiply/divide unit
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  // Multiply/divide sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_t;

endpackage
`default_nettype wire

// File: rtl/mdu_core.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : mdu_core                                                     |
// | Purpose : Iterative multiply/divide datapath. Captures operand         |
// |           magnitudes and signs, runs one shift-add or restoring-divide |
// |           step per cycle, and presents sign-corrected HI/LO results.   |
// | Ports   : clk, reset      clock / synchronous active-high reset        |
// |           load            capture a, b and the operation this cycle    |
// |           op_div          1 = divide, 0 = multiply (with load)         |
// |           op_signed       signed operation (with load)                 |
// |           a, b            rs / rt operands                             |
// |           step            perform one iteration                        |
// |           last            current iteration is the final one           |
// |           hi_res, lo_res  corrected result, valid after last step      |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module mdu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic             last,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam int CNT_W = $clog2(WIDTH);

  // acc: product high half / partial remainder
  // lo : multiplier shifting out / dividend shifting out, quotient in
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0] dividend;   // raw dividend, returned on divide by zero
  logic [CNT_W-1:0] count;
  logic             is_div;
  logic             neg_q;      // product / quotient must be negated
  logic             neg_r;      // remainder must be negated
  logic             div_zero;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  assign a_mag = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (op_signed && b[WIDTH-1]) ? -b : b;

  assign last = (count == CNT_W'(WIDTH - 1));

  // One shift-add multiply step: add when the multiplier LSB is set,
  // then shift {sum, multiplier} right by one.
  assign mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

  // One restoring-divide step: shift the next dividend bit into the
  // remainder and keep the difference only if it did not go negative.
  assign div_shift = {acc, lo[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      lo       <= '0;
      opnd     <= '0;
      dividend <= '0;
      count    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (load) begin
      acc      <= '0;
      lo       <= a_mag;
      opnd     <= b_mag;
      dividend <= a;
      count    <= '0;
      is_div   <= op_div;
      neg_q    <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r    <= op_signed && a[WIDTH-1];
      div_zero <= (b == '0);
    end else if (step) begin
      count <= last ? '0 : count + CNT_W'(1);
      if (is_div) begin
        if (!div_diff[WIDTH+1]) begin
          acc <= div_diff[WIDTH-1:0];
          lo  <= {lo[WIDTH-2:0], 1'b1};
        end else begin
          acc <= div_shift[WIDTH-1:0];
          lo  <= {lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc <= mul_sum[WIDTH:1];
        lo  <= {mul_sum[0], lo[WIDTH-1:1]};
      end
    end
  end

  // Sign correction. Most-negative / -1 needs no special case: the
  // magnitude quotient is 2^(WIDTH-1) with equal signs, which already
  // reads back as the most-negative value with a zero remainder.
  assign prod     = {acc, lo};
  assign prod_fix = neg_q ? -prod : prod;

  always_comb begin
    hi_res = prod_fix[2*WIDTH-1:WIDTH];
    lo_res = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        hi_res = dividend;
        lo_res = '1;
      end else begin
        hi_res = neg_r ? -acc : acc;
        lo_res = neg_q ? -lo : lo;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_md_control.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : alu_md_control                                               |
// | Purpose : ALU control decoder plus HI/LO registers and the sequencer   |
// |           for an iterative multiply/divide unit.                       |
// | Ports   : clk, reset   clock / synchronous active-high reset           |
// |           ALUOp        0 add, 1 sub, 2 decode Function, 3 reserved     |
// |           Function     R-type funct field                              |
// |           start        qualifies a mult/div/mthi/mtlo request          |
// |           A, B         rs / rt operands                                |
// |           ALUCtrl      ALU operation code (combinational)              |
// |           illegal      unrecognised ALUOp/funct (combinational)        |
// |           busy         multiply/divide in progress (registered)        |
// |           done         one-cycle pulse when HI/LO take a result        |
// |           hilo_out     HI for mfhi, LO otherwise (combinational)       |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module alu_md_control
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        Function,
  input  logic              start,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  output logic [CTRL_W-1:0] ALUCtrl,
  output logic              illegal,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  hilo_out
);

  md_state_t        state;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [3:0]       ctrl;

  logic             funct_req;
  logic             req_mul;
  logic             req_div;
  logic             req_mthi;
  logic             req_mtlo;
  logic             op_signed;
  logic             accept;
  logic             core_load;
  logic             core_step;
  logic             core_last;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;

  // ALU control decode
  always_comb begin
    ctrl    = CTRL_ADD;
    illegal = 1'b0;
    case (ALUOp)
      ALUOP_ADD: ctrl = CTRL_ADD;
      ALUOP_SUB: ctrl = CTRL_SUB;
      ALUOP_FUNCT: begin
        case (Function)
          F_ADD:   ctrl = CTRL_ADD;
          F_SUB:   ctrl = CTRL_SUB;
          F_AND:   ctrl = CTRL_AND;
          F_OR:    ctrl = CTRL_OR;
          F_XOR:   ctrl = CTRL_XOR;
          F_NOR:   ctrl = CTRL_NOR;
          F_SLT:   ctrl = CTRL_SLT;
          F_MULT, F_MULTU, F_DIV, F_DIVU,
          F_MFHI, F_MTHI, F_MFLO, F_MTLO:
                   ctrl = CTRL_ADD;
          default: illegal = 1'b1;
        endcase
      end
      ALUOP_RSVD: illegal = 1'b1;
      default:    illegal = 1'b1;
    endcase
  end

  assign ALUCtrl = CTRL_W'(ctrl);

  // Request qualification; requests are only honoured when not busy
  assign funct_req = start && (ALUOp == ALUOP_FUNCT);
  assign req_mul   = funct_req && ((Function == F_MULT) || (Function == F_MULTU));
  assign req_div   = funct_req && ((Function == F_DIV)  || (Function == F_DIVU));
  assign req_mthi  = funct_req && (Function == F_MTHI);
  assign req_mtlo  = funct_req && (Function == F_MTLO);
  assign op_signed = (Function == F_MULT) || (Function == F_DIV);

  assign accept    = (state == ST_IDLE) || (state == ST_DONE);
  assign core_load = accept && (req_mul || req_div);
  assign core_step = (state == ST_MUL) || (state == ST_DIV);

  mdu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (core_load),
    .op_div    (req_div),
    .op_signed (op_signed),
    .a         (A),
    .b         (B),
    .step      (core_step),
    .last      (core_last),
    .hi_res    (core_hi),
    .lo_res    (core_lo)
  );

  // Sequencer with registered busy/done
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (req_mul) begin
            state <= ST_MUL;
            busy  <= 1'b1;
          end else if (req_div) begin
            state <= ST_DIV;
            busy  <= 1'b1;
          end else if (req_mthi) begin
            hi <= A;
          end else if (req_mtlo) begin
            lo <= A;
          end
        end
        ST_MUL, ST_DIV: begin
          if (core_last) state <= ST_FIX;
        end
        ST_FIX: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          hi    <= core_hi;
          lo    <= core_lo;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign hilo_out = (Function == F_MFHI) ? hi : lo;

endmodule
`default_nettype wire

// File: tb/tb_alu_md_control.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_alu_md_control                                            |
// | Purpose : Scoreboard bench for alu_md_control. Stimulus pushes the     |
// |           expected values; a negedge monitor pops and compares on the  |
// |           done pulse and on explicit observation strobes.              |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_alu_md_control;
  import alu_pkg::*;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 4;
  localparam int K_OUT  = 0;
  localparam int K_DEC  = 1;
  localparam int K_STAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        ALUOp;
  logic [5:0]        Function;
  logic              start;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic [CTRL_W-1:0] ALUCtrl;
  logic              illegal;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  hilo_out;

  always #5 clk = ~clk;

  alu_md_control #(
    .WIDTH  (WIDTH),
    .CTRL_W (CTRL_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ALUOp    (ALUOp),
    .Function (Function),
    .start    (start),
    .A        (A),
    .B        (B),
    .ALUCtrl  (ALUCtrl),
    .illegal  (illegal),
    .busy     (busy),
    .done     (done),
    .hilo_out (hilo_out)
  );

  int checks    = 0;
  int errors    = 0;
  int done_seen = 0;

  // observation scoreboard
  int          kind_q[$];
  logic [63:0] val_q[$];
  string       name_q[$];
  logic        obs_en = 1'b0;

  // expected LO at each done pulse
  logic [WIDTH-1:0] done_exp_q[$];
  string            done_name_q[$];

  int          m_kind;
  logic [63:0] m_act;
  logic [63:0] m_exp;
  string       m_name;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_seen++;
      if (done_exp_q.size() == 0) begin
        cmp("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        m_name = done_name_q.pop_front();
        m_exp  = {32'd0, done_exp_q.pop_front()};
        cmp(m_name, {32'd0, hilo_out}, m_exp);
      end
    end
    if (obs_en) begin
      if (kind_q.size() == 0) begin
        cmp("obs_queue_empty", 64'(kind_q.size()), 64'd1);
      end else begin
        m_kind = kind_q.pop_front();
        m_exp  = val_q.pop_front();
        m_name = name_q.pop_front();
        case (m_kind)
          K_OUT:   m_act = {32'd0, hilo_out};
          K_DEC:   m_act = {59'd0, ALUCtrl, illegal};
          default: m_act = {62'd0, busy, done};
        endcase
        cmp(m_name, m_act, m_exp);
      end
    end
  end

  // Queue one expectation and strobe the monitor at the next negedge
  task automatic expect_now(input int kind, input logic [63:0] v, input string name);
    kind_q.push_back(kind);
    val_q.push_back(v);
    name_q.push_back(name);
    obs_en = 1'b1;
    @(negedge clk);
    #1 obs_en = 1'b0;
  endtask

  // Present a request for exactly one rising edge
  task automatic launch(input logic [5:0] f, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input bit now);
    if (!now) @(negedge clk);
    #1;
    ALUOp    = ALUOP_FUNCT;
    Function = f;
    A        = a;
    B        = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    Function = F_MFLO;
  endtask

  // Count negedges after the accepting edge until done is seen
  task automatic wait_done(input int n0, input string name);
    int n;
    bit got;
    n   = n0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) got = 1'b1;
    end
    cmp({name, "_latency"}, 64'(n), 64'(WIDTH + 2));
  endtask

  task automatic md_op(input logic [5:0] f, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] hi_e,
                       input logic [WIDTH-1:0] lo_e, input string name,
                       input bit now, input bit readback);
    done_exp_q.push_back(lo_e);
    done_name_q.push_back({name, "_lo_at_done"});
    launch(f, a, b, now);
    wait_done(0, name);
    if (readback) begin
      #1 Function = F_MFHI;
      expect_now(K_OUT, {32'd0, hi_e}, {name, "_hi"});
      Function = F_MFLO;
      expect_now(K_OUT, {32'd0, lo_e}, {name, "_lo"});
    end
  endtask

  logic [1:0] d_op [14];
  logic [5:0] d_fn [14];
  logic [3:0] d_ct [14];
  logic       d_il [14];

  initial begin
    int ds;
    d_op = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    d_fn = '{6'b100100, 6'b000000, 6'b101010, 6'b100000, 6'b100010, 6'b100100, 6'b100101,
             6'b100110, 6'b100111, 6'b101010, 6'b000000, 6'b011000, 6'b010000, 6'b111111};
    d_ct = '{4'b0110, 4'b1110, 4'b0110, 4'b0110, 4'b1110, 4'b0000, 4'b0001,
             4'b0010, 4'b0011, 4'b1111, 4'b0110, 4'b0110, 4'b0110, 4'b0110};
    d_il = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    reset    = 1'b1;
    start    = 1'b0;
    ALUOp    = ALUOP_FUNCT;
    Function = F_MFLO;
    A        = '0;
    B        = '0;

    // reset behaviour
    repeat (2) @(negedge clk);
    #1;
    expect_now(K_STAT, 64'd0, "stat_in_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    expect_now(K_STAT, 64'd0, "stat_after_reset");
    expect_now(K_OUT, 64'd0, "lo_after_reset");
    Function = F_MFHI;
    expect_now(K_OUT, 64'd0, "hi_after_reset");
    Function = F_MFLO;

    // ALU control decode
    for (int i = 0; i < 14; i++) begin
      ALUOp    = d_op[i];
      Function = d_fn[i];
      expect_now(K_DEC, {59'd0, d_ct[i], d_il[i]}, $sformatf("decode_%0d", i));
    end
    ALUOp    = ALUOP_FUNCT;
    Function = F_MFLO;

    // multiply / divide vectors
    md_op(F_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg",   1'b0, 1'b1);
    md_op(F_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, "multu",      1'b0, 1'b1);
    md_op(F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg",    1'b0, 1'b1);
    md_op(F_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, "divu_zero",  1'b0, 1'b1);
    md_op(F_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, "div_zero",   1'b0, 1'b1);
    md_op(F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf",    1'b0, 1'b1);
    md_op(F_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_negb",   1'b0, 1'b1);

    // new request accepted while in DONE
    md_op(F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu_b2b",   1'b0, 1'b0);
    md_op(F_MULT,  32'hFFFFFFF9, 32'hFFFFFFFD, 32'd0,        32'd21,       "mult_b2b",   1'b1, 1'b1);

    // mthi while busy is ignored
    done_exp_q.push_back(32'd0);
    done_name_q.push_back("busy_mthi_lo_at_done");
    launch(F_MULTU, 32'h00010000, 32'h00010000, 1'b0);
    Function = F_MTHI;
    A        = 32'h12345678;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    Function = F_MFLO;
    wait_done(1, "busy_mthi");
    #1 Function = F_MFHI;
    expect_now(K_OUT, 64'h1, "busy_mthi_hi");
    Function = F_MFLO;
    expect_now(K_OUT, 64'h0, "busy_mthi_lo");

    // mthi / mtlo when idle
    launch(F_MTHI, 32'h12345678, 32'd0, 1'b0);
    Function = F_MFHI;
    expect_now(K_OUT, 64'h12345678, "mthi_idle");
    launch(F_MTLO, 32'hCAFEF00D, 32'd0, 1'b0);
    expect_now(K_OUT, 64'hCAFEF00D, "mtlo_idle");
    Function = F_MFHI;
    expect_now(K_OUT, 64'h12345678, "hi_kept_after_mtlo");
    Function = F_MFLO;

    // reset during a multiply aborts it
    launch(F_MULT, 32'd5, 32'd6, 1'b0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    expect_now(K_STAT, 64'd0, "abort_stat");
    expect_now(K_OUT, 64'd0, "abort_lo");
    Function = F_MFHI;
    expect_now(K_OUT, 64'd0, "abort_hi");
    Function = F_MFLO;
    ds = done_seen;
    repeat (40) @(negedge clk);
    cmp("abort_no_done", 64'(done_seen - ds), 64'd0);

    cmp("pending_done_expectations", 64'(done_exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
